// File: rtl/s2c_pull_streamer_if.sv
// Bus bundle for s2c_pull_streamer: command, chunk request, pull response and output stream.
// The master modport is the streamer's view; slave is the bench/wrapper side.
interface s2c_pull_streamer_if #(
  parameter int unsigned DATA_SIZE = 16
);
  logic                      start;
  logic [31:0]               base_addr;
  logic [31:0]               total_words;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic                      req_valid;
  logic                      req_ready;
  logic [31:0]               req_id;
  logic [31:0]               req_fn;
  logic [31:0]               req_addr;
  logic [31:0]               req_size;
  logic                      rsp_valid;
  logic [31:0]               rsp_ret;
  logic [32*DATA_SIZE-1:0]   rsp_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [31:0]               m_data;
  logic                      m_last;

  modport master (
    input  start, base_addr, total_words, req_ready, rsp_valid, rsp_ret, rsp_data, m_ready,
    output busy, done, error, req_valid, req_id, req_fn, req_addr, req_size,
    output m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, total_words, req_ready, rsp_valid, rsp_ret, rsp_data, m_ready,
    input  busy, done, error, req_valid, req_id, req_fn, req_addr, req_size,
    input  m_valid, m_data, m_last
  );
endinterface

// File: rtl/s2c_pull_streamer.sv
// Splits a transfer command into pull requests of at most DATA_SIZE words and streams the
// returned words out. Define S2C_PULL_PREFETCH_EN for ping/pong buffering with request prefetch.
module s2c_pull_streamer #(
  parameter int unsigned DATA_SIZE = 16,
  parameter logic [31:0] ID        = 32'd0,
  parameter logic [31:0] FN        = 32'd1
) (
  input logic                 clk,
  input logic                 rst_n,
  s2c_pull_streamer_if.master io_bus
);

  localparam int unsigned IdxW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int unsigned CntW = IdxW + 1;

`ifdef S2C_PULL_PREFETCH_EN
  localparam logic PingPong = 1'b1;
`else
  localparam logic PingPong = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StFin} state_e;

  state_e          r_state, w_state_nxt;
  logic [31:0]     r_addr, w_addr_nxt;
  logic [31:0]     r_rem, w_rem_nxt;
  logic            r_error, w_error_nxt;
  logic            r_req_act, w_req_act_nxt;
  logic            r_wait, w_wait_nxt;
  logic [1:0]      r_full, w_full_nxt;
  logic            r_rd, w_rd_nxt;
  logic            r_wr, w_wr_nxt;
  logic [IdxW-1:0] r_idx, w_idx_nxt;
  logic [CntW-1:0] r_cnt [2];
  logic [31:0]     r_buf [2][DATA_SIZE];

  logic [31:0] w_chunk;
  logic        w_m_valid;
  logic        w_last_in_bank;
  logic        w_hs_req;
  logic        w_hs_m;
  logic        w_rsp;
  logic        w_rsp_ok;

  assign w_chunk        = (r_rem < 32'(DATA_SIZE)) ? r_rem : 32'(DATA_SIZE);
  assign w_m_valid      = r_full[r_rd];
  assign w_last_in_bank = (({1'b0, r_idx} + CntW'(1)) == r_cnt[r_rd]);
  assign w_hs_req       = r_req_act & io_bus.req_ready;
  assign w_hs_m         = w_m_valid & io_bus.m_ready;
  assign w_rsp          = r_wait & io_bus.rsp_valid;
  assign w_rsp_ok       = w_rsp & (io_bus.rsp_ret == 32'd0);

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_rem_nxt     = r_rem;
    w_error_nxt   = r_error;
    w_req_act_nxt = r_req_act;
    w_wait_nxt    = r_wait;
    w_full_nxt    = r_full;
    w_rd_nxt      = r_rd;
    w_wr_nxt      = r_wr;
    w_idx_nxt     = r_idx;

    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_error_nxt = 1'b0;
          w_addr_nxt  = io_bus.base_addr;
          w_rem_nxt   = io_bus.total_words;
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_idx_nxt   = '0;
          if (io_bus.total_words == 32'd0) begin
            w_state_nxt = StFin;
          end else begin
            w_req_act_nxt = 1'b1;
            w_state_nxt   = StReq;
          end
        end
      end
      StFin: w_state_nxt = StIdle;
      default: begin
        if (w_hs_req) begin
          w_req_act_nxt = 1'b0;
          w_wait_nxt    = 1'b1;
        end
        if (w_rsp) begin
          w_wait_nxt = 1'b0;
          if (w_rsp_ok) begin
            w_full_nxt[r_wr] = 1'b1;
            w_wr_nxt         = r_wr ^ PingPong;
            w_addr_nxt       = r_addr + {w_chunk[29:0], 2'b00};
            w_rem_nxt        = r_rem - w_chunk;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
        if (w_hs_m) begin
          if (w_last_in_bank) begin
            w_full_nxt[r_rd] = 1'b0;
            w_rd_nxt         = r_rd ^ PingPong;
            w_idx_nxt        = '0;
          end else begin
            w_idx_nxt = r_idx + IdxW'(1);
          end
        end
        // A new chunk may be requested as soon as the bank it will land in is free.
        if (!w_error_nxt && (w_rem_nxt != 32'd0) && !w_req_act_nxt && !w_wait_nxt &&
            !w_full_nxt[w_wr_nxt]) begin
          w_req_act_nxt = 1'b1;
        end
        if (!w_req_act_nxt && !w_wait_nxt && (w_full_nxt == 2'b00) &&
            ((w_rem_nxt == 32'd0) || w_error_nxt)) begin
          w_state_nxt = StFin;
        end else if (w_full_nxt[w_rd_nxt]) begin
          w_state_nxt = StDrain;
        end else if (w_req_act_nxt) begin
          w_state_nxt = StReq;
        end else begin
          w_state_nxt = StWait;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_rem     <= '0;
      r_error   <= 1'b0;
      r_req_act <= 1'b0;
      r_wait    <= 1'b0;
      r_full    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_rem     <= w_rem_nxt;
      r_error   <= w_error_nxt;
      r_req_act <= w_req_act_nxt;
      r_wait    <= w_wait_nxt;
      r_full    <= w_full_nxt;
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_idx     <= w_idx_nxt;
    end
  end

  // Whole response is captured; only the first r_cnt words are ever streamed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        r_cnt[b] <= '0;
        for (int k = 0; k < int'(DATA_SIZE); k++) begin
          r_buf[b][k] <= '0;
        end
      end
    end else if (w_rsp_ok) begin
      r_cnt[r_wr] <= w_chunk[CntW-1:0];
      for (int k = 0; k < int'(DATA_SIZE); k++) begin
        r_buf[r_wr][k] <= io_bus.rsp_data[32*k +: 32];
      end
    end
  end

  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.done      = (r_state == StFin);
  assign io_bus.error     = r_error;
  assign io_bus.req_valid = r_req_act;
  assign io_bus.req_id    = r_req_act ? ID : '0;
  assign io_bus.req_fn    = r_req_act ? FN : '0;
  assign io_bus.req_addr  = r_req_act ? r_addr : '0;
  assign io_bus.req_size  = r_req_act ? w_chunk : '0;
  assign io_bus.m_valid   = w_m_valid;
  assign io_bus.m_data    = w_m_valid ? r_buf[r_rd][r_idx] : '0;
  // Final word only when nothing else is buffered, pending or still to be requested.
  assign io_bus.m_last    = w_m_valid & w_last_in_bank & (r_rem == 32'd0) & ~r_wait &
                            ~r_req_act & ~r_full[~r_rd];

endmodule

// File: tb/tb_s2c_pull_streamer.sv
// Self-checking bench for s2c_pull_streamer: vector table, corner-case sequences and
// randomized transfers scored against a chunk/word reference model.
module tb_s2c_pull_streamer;
  localparam int unsigned DS = 16;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  s2c_pull_streamer_if #(.DATA_SIZE(DS)) bus ();

  s2c_pull_streamer #(
    .DATA_SIZE(DS),
    .ID       (32'd0),
    .FN       (32'd1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] base;
    logic [31:0] total;
    int          err;
    int          mmode;
    int          rmode;
    int          exp_words;
    int          exp_reqs;
    logic        exp_err;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " flags"}, {26'd0, bus.busy, bus.done, bus.error, bus.req_valid, bus.m_valid,
                          bus.m_last}, 32'd0);
    chk({tag, " req_addr"}, bus.req_addr, 32'd0);
    chk({tag, " req_size"}, bus.req_size, 32'd0);
    chk({tag, " m_data"}, bus.m_data, 32'd0);
  endtask

  task automatic stray_rsp(input string tag);
    logic any;
    any = 1'b0;
    @(negedge clk);
    bus.rsp_valid = 1'b1;
    bus.rsp_ret   = 32'd0;
    for (int k = 0; k < int'(DS); k++) bus.rsp_data[32*k +: 32] = $urandom;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any = any | bus.busy | bus.m_valid | bus.req_valid | bus.done;
      @(negedge clk);
    end
    chk({tag, " stray rsp ignored"}, {31'd0, any}, 32'd0);
  endtask

  // mmode/rmode: 0 random, 1 always ready, 2 pattern (m: 1,0,0,1,0,1; req: low 5 cycles).
  task automatic run_xfer(input logic [31:0] base, input logic [31:0] total, input int err,
                          input int mmode, input int rmode, input int dly,
                          input int exp_words, input int exp_reqs, input logic exp_err,
                          input bit pf_chk);
    int nreq, nword, ndone, cd, ridx, mtog, rlow, first_w, last_w;
    bit seen_done, rv_stall, mv_stall, rsp_ok_prev, drain_req, finished;
    logic rr, mr, pm_last;
    logic [31:0] pr_addr, pr_size, pm_data, exp_a, exp_s, rem, rsp_a, rsp_s;
    int mpat [6];
    mpat = '{1, 0, 0, 1, 0, 1};
    nreq = 0; nword = 0; ndone = 0; cd = 0; ridx = 0; mtog = 0; rlow = 0;
    first_w = -1; last_w = -1;
    seen_done = 0; rv_stall = 0; mv_stall = 0; rsp_ok_prev = 0; drain_req = 0; finished = 0;
    pr_addr = '0; pr_size = '0; pm_data = '0; pm_last = 1'b0; rsp_a = '0; rsp_s = '0;

    @(negedge clk);
    bus.start       = 1'b1;
    bus.base_addr   = base;
    bus.total_words = total;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start busy", {31'd0, bus.busy}, 32'd1);
    chk("start error cleared", {31'd0, bus.error}, 32'd0);
    chk("first req_valid", {31'd0, bus.req_valid}, {31'd0, total != 32'd0});

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (seen_done) begin
        chk("busy after done", {31'd0, bus.busy}, 32'd0);
        chk("done one cycle", {31'd0, bus.done}, 32'd0);
        finished = 1;
      end else begin
        if (bus.done) begin
          ndone++;
          seen_done = 1;
          chk("m_valid at done", {31'd0, bus.m_valid}, 32'd0);
        end
        if (rsp_ok_prev) chk("m_valid after rsp", {31'd0, bus.m_valid}, 32'd1);
        rsp_ok_prev   = 0;
        bus.rsp_valid = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_ret   = (ridx == err) ? 32'hFFFF_FFFF : 32'd0;
            for (int k = 0; k < int'(DS); k++) begin
              bus.rsp_data[32*k +: 32] = (32'(k) < rsp_s) ? mem_word(rsp_a + 32'(4 * k))
                                                           : $urandom;
            end
            rsp_ok_prev = (ridx != err);
          end
        end

        if (rv_stall) begin
          chk("req_valid held", {31'd0, bus.req_valid}, 32'd1);
          chk("req_addr stable", bus.req_addr, pr_addr);
          chk("req_size stable", bus.req_size, pr_size);
        end
        rr = 1'b0;
        if (bus.req_valid) begin
          case (rmode)
            0:       rr = 1'($urandom_range(0, 1));
            1:       rr = 1'b1;
            default: begin rr = (rlow >= 5); rlow++; end
          endcase
          if (bus.m_valid) drain_req = 1;
          if (rr) begin
            exp_a = base + (32'(nreq) << 6);
            rem   = total - (32'(nreq) << 4);
            exp_s = (rem > 32'(DS)) ? 32'(DS) : rem;
            if (nreq < exp_reqs) begin
              chk("req_addr", bus.req_addr, exp_a);
              chk("req_size", bus.req_size, exp_s);
              chk("req_id", bus.req_id, 32'd0);
              chk("req_fn", bus.req_fn, 32'd1);
            end else begin
              chk("extra request", 32'd1, 32'd0);
            end
            rsp_a = exp_a;
            rsp_s = exp_s;
            ridx  = nreq;
            nreq++;
            cd = (dly > 0) ? dly : int'($urandom_range(1, 4));
          end
          pr_addr = bus.req_addr;
          pr_size = bus.req_size;
        end
        rv_stall      = bus.req_valid && !rr;
        bus.req_ready = rr;

        if (mv_stall) begin
          chk("m_valid held", {31'd0, bus.m_valid}, 32'd1);
          chk("m_data stable", bus.m_data, pm_data);
          chk("m_last stable", {31'd0, bus.m_last}, {31'd0, pm_last});
        end
        mr = 1'b0;
        if (bus.m_valid) begin
          case (mmode)
            0:       mr = 1'($urandom_range(0, 1));
            1:       mr = 1'b1;
            default: begin mr = (mpat[mtog % 6] != 0); mtog++; end
          endcase
          if (mr) begin
            if (nword < exp_words) begin
              chk("m_data", bus.m_data, mem_word(base + 32'(4 * nword)));
              chk("m_last", {31'd0, bus.m_last},
                  {31'd0, !exp_err && (nword == exp_words - 1)});
            end else begin
              chk("extra word", 32'd1, 32'd0);
            end
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
            nword++;
          end
          pm_data = bus.m_data;
          pm_last = bus.m_last;
        end
        mv_stall    = bus.m_valid && !mr;
        bus.m_ready = mr;
      end
      @(negedge clk);
    end
    if (!finished) chk("transfer timeout", 32'd0, 32'd1);
    bus.req_ready = 1'b0;
    bus.m_ready   = 1'b0;
    bus.rsp_valid = 1'b0;
    chk("word count", 32'(nword), 32'(exp_words));
    chk("request count", 32'(nreq), 32'(exp_reqs));
    chk("done pulses", 32'(ndone), 32'd1);
    chk("error flag", {31'd0, bus.error}, {31'd0, exp_err});
    if (pf_chk) begin
      chk("prefetch req during drain", {31'd0, drain_req}, 32'd1);
      chk("prefetch contiguous", 32'(last_w - first_w + 1), 32'(exp_words));
    end
  endtask

  initial begin
    vec_t tbl [7];
    int   total, nch, err, ew, er;
    logic [31:0] base;

    tbl[0] = '{32'h0000_1000, 32'd40, -1, 1, 1, 40, 3, 1'b0};
    tbl[1] = '{32'h0000_2000, 32'd20,  1, 1, 1, 16, 2, 1'b1};
    tbl[2] = '{32'h0000_3000, 32'd3,  -1, 2, 2,  3, 1, 1'b0};
    tbl[3] = '{32'hFFFF_FFF0, 32'd20, -1, 0, 0, 20, 2, 1'b0};
    tbl[4] = '{32'h0000_4000, 32'd16, -1, 0, 1, 16, 1, 1'b0};
    tbl[5] = '{32'h0000_5000, 32'd17, -1, 1, 0, 17, 2, 1'b0};
    tbl[6] = '{32'h0000_6000, 32'd5,   0, 0, 0,  0, 1, 1'b1};

    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.base_addr   = '0;
    bus.total_words = '0;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_ret     = '0;
    bus.rsp_data    = '0;
    bus.m_ready     = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("reset req_id", bus.req_id, 32'd0);
    chk("reset req_fn", bus.req_fn, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_xfer(tbl[i].base, tbl[i].total, tbl[i].err, tbl[i].mmode, tbl[i].rmode, 0,
               tbl[i].exp_words, tbl[i].exp_reqs, tbl[i].exp_err, 1'b0);
    end

    stray_rsp("idle");

    // Zero-length command.
    @(negedge clk);
    bus.start       = 1'b1;
    bus.total_words = 32'd0;
    bus.base_addr   = 32'h0000_0100;
    @(negedge clk);
    bus.start = 1'b0;
    chk("zero busy", {31'd0, bus.busy}, 32'd1);
    chk("zero done", {31'd0, bus.done}, 32'd1);
    chk("zero req_valid", {31'd0, bus.req_valid}, 32'd0);
    @(negedge clk);
    chk("zero busy drop", {31'd0, bus.busy}, 32'd0);
    chk("zero done drop", {31'd0, bus.done}, 32'd0);
    chk("zero no req", {31'd0, bus.req_valid}, 32'd0);

    // Reset while waiting for a response.
    @(negedge clk);
    bus.start       = 1'b1;
    bus.base_addr   = 32'h0000_7000;
    bus.total_words = 32'd20;
    bus.req_ready   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.req_ready = 1'b0;
    chk("wait busy", {31'd0, bus.busy}, 32'd1);
    chk("wait no req", {31'd0, bus.req_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    stray_rsp("after reset");
    run_xfer(32'h0000_8000, 32'd4, -1, 1, 1, 0, 4, 1, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      total = int'($urandom_range(1, 50));
      base  = $urandom & 32'hFFFF_FFFC;
      nch   = (total + int'(DS) - 1) / int'(DS);
      err   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nch - 1)) : -1;
      ew    = (err >= 0) ? err * int'(DS) : total;
      er    = (err >= 0) ? err + 1 : nch;
      run_xfer(base, 32'(total), err, 0, 0, 0, ew, er, err >= 0, 1'b0);
    end

`ifdef S2C_PULL_PREFETCH_EN
    run_xfer(32'h0000_9000, 32'd32, -1, 1, 1, 1, 32, 2, 1'b0, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
